dbram_store_drain: RTL and testbench

- Writer-side front end for the 64-bit byte-enable data BRAM (1024 x 64, read-first, per-byte write enables).
- Accepts committed stores into a small FIFO and coalesces a store into the youngest entry when the word addresses match.
- Drains one entry per cycle into the BRAM write port through a registered output stage.
- Reports load-address hazards against every pending store so the load pipe can replay or forward.

---
 rtl/dbram_pkg.sv | 31 +++
 rtl/dbram_store_drain_if.sv | 44 ++++
 rtl/dbram_store_drain_hazard_cam.sv | 73 +++++++
 rtl/dbram_store_drain.sv | 119 +++++++++++
 tb/tb_dbram_store_drain.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dbram_pkg.sv
// Shared types and helpers for the data-BRAM store path: word/byte widths,
// the store-buffer entry record and a per-byte merge used by coalescing and forwarding.
package dbram_pkg;

    localparam int DBRAM_AW = 10;
    localparam int DBRAM_DW = 64;
    localparam int DBRAM_BE = DBRAM_DW / 8;

    typedef struct packed {
        logic                valid;
        logic [DBRAM_AW-1:0] addr;
        logic [DBRAM_DW-1:0] data;
        logic [DBRAM_BE-1:0] be;
    } sd_entry_t;

    function automatic logic [DBRAM_DW-1:0] byte_merge(
        input logic [DBRAM_DW-1:0] old_data,
        input logic [DBRAM_DW-1:0] new_data,
        input logic [DBRAM_BE-1:0] be
    );
        logic [DBRAM_DW-1:0] merged;
        merged = old_data;
        for (int i = 0; i < DBRAM_BE; i++) begin
            if (be[i]) begin
                merged[i*8 +: 8] = new_data[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dbram_store_drain_if.sv
// Store-drain bus: store enqueue, BRAM write port, load hazard probe.
// STORE_DRAIN_FWD_EN adds the load forwarding data/byte-enable signals.
interface dbram_store_drain_if
    import dbram_pkg::*;
#(
    parameter int AW = DBRAM_AW,
    parameter int DW = DBRAM_DW
) ();

    logic            enq_valid;
    logic            enq_ready;
    logic [AW-1:0]   enq_addr;
    logic [DW-1:0]   enq_data;
    logic [DW/8-1:0] enq_be;
    logic            drain_stall;
    logic [DW/8-1:0] ram_wr_en;
    logic [AW-1:0]   ram_wr_addr;
    logic [DW-1:0]   ram_wr_data;
    logic            ld_valid;
    logic [AW-1:0]   ld_addr;
    logic            ld_hit;
    logic            sb_empty;
`ifdef STORE_DRAIN_FWD_EN
    logic [DW-1:0]   ld_fwd_data;
    logic [DW/8-1:0] ld_fwd_be;
`endif

    modport master (
        output enq_valid, enq_addr, enq_data, enq_be, drain_stall, ld_valid, ld_addr,
`ifdef STORE_DRAIN_FWD_EN
        input  ld_fwd_data, ld_fwd_be,
`endif
        input  enq_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ld_hit, sb_empty
    );

    modport slave (
        input  enq_valid, enq_addr, enq_data, enq_be, drain_stall, ld_valid, ld_addr,
`ifdef STORE_DRAIN_FWD_EN
        output ld_fwd_data, ld_fwd_be,
`endif
        output enq_ready, ram_wr_en, ram_wr_addr, ram_wr_data, ld_hit, sb_empty
    );

endinterface

// File: rtl/dbram_store_drain_hazard_cam.sv
// sd_hazard_cam: matches a load word address against every pending store and the
// BRAM output stage; STORE_DRAIN_FWD_EN adds a youngest-wins per-byte forward merge.
module sd_hazard_cam
    import dbram_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  sd_entry_t                entries [DEPTH],
    input  logic [DBRAM_BE-1:0]      out_en,
    input  logic [DBRAM_AW-1:0]      out_addr,
    input  logic                     ld_valid,
    input  logic [DBRAM_AW-1:0]      ld_addr,
`ifdef STORE_DRAIN_FWD_EN
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [DBRAM_DW-1:0]      out_data,
    output logic [DBRAM_DW-1:0]      ld_fwd_data,
    output logic [DBRAM_BE-1:0]      ld_fwd_be,
`endif
    output logic                     ld_hit
);

    localparam int PW = $clog2(DEPTH);

    logic any_match;

    // The output stage counts because the BRAM is read-first during its write cycle.
    always_comb begin
        any_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entries[i].valid && entries[i].addr == ld_addr && entries[i].be != '0) begin
                any_match = 1'b1;
            end
        end
        if (out_en != '0 && out_addr == ld_addr) begin
            any_match = 1'b1;
        end
        ld_hit = ld_valid && any_match;
    end

`ifdef STORE_DRAIN_FWD_EN
    logic [PW-1:0] idx;

    // Walk oldest to youngest (output stage, then head onward) so younger bytes overwrite.
    always_comb begin
        ld_fwd_data = '0;
        ld_fwd_be   = '0;
        idx         = head;
        if (ld_valid) begin
            if (out_en != '0 && out_addr == ld_addr) begin
                ld_fwd_data = byte_merge(ld_fwd_data, out_data, out_en);
                ld_fwd_be   = ld_fwd_be | out_en;
            end
            for (int i = 0; i < DEPTH; i++) begin
                idx = head + PW'(i);
                if (entries[idx].valid && entries[idx].addr == ld_addr) begin
                    ld_fwd_data = byte_merge(ld_fwd_data, entries[idx].data, entries[idx].be);
                    ld_fwd_be   = ld_fwd_be | entries[idx].be;
                end
            end
        end
    end
`else
    logic unused_data;

    always_comb begin
        unused_data = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_data = unused_data ^ (^entries[i].data);
        end
    end
`endif

endmodule

// File: rtl/dbram_store_drain.sv
// Store buffer in front of the byte-enable data BRAM: coalesces into the youngest entry,
// drains one entry per cycle through registered write outputs. Optional: STORE_DRAIN_FWD_EN.
module dbram_store_drain
    import dbram_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int AW    = DBRAM_AW,
    parameter int DW    = DBRAM_DW
) (
    input logic               clk,
    input logic               rst,
    dbram_store_drain_if.slave sd
);

    localparam int BE = DW / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    sd_entry_t     entries_q [DEPTH];
    sd_entry_t     entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [BE-1:0] ram_wr_en_q, ram_wr_en_d;
    logic [AW-1:0] ram_wr_addr_q, ram_wr_addr_d;
    logic [DW-1:0] ram_wr_data_q, ram_wr_data_d;

    logic          enq_ready;
    logic          accept;
    logic          pop;
    logic          coalesce;
    logic [PW-1:0] youngest;

    assign enq_ready = (count_q != CW'(DEPTH));

    // Coalescing is blocked when the youngest entry is the one leaving this cycle.
    always_comb begin
        entries_d     = entries_q;
        head_d        = head_q;
        tail_d        = tail_q;
        ram_wr_en_d   = '0;
        ram_wr_addr_d = ram_wr_addr_q;
        ram_wr_data_d = ram_wr_data_q;

        youngest = tail_q - PW'(1);
        accept   = sd.enq_valid && enq_ready;
        pop      = (count_q != '0) && !sd.drain_stall;
        coalesce = accept && entries_q[youngest].valid
                   && (entries_q[youngest].addr == sd.enq_addr)
                   && !(pop && (youngest == head_q));

        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d        = head_q + PW'(1);
            ram_wr_en_d   = entries_q[head_q].be;
            ram_wr_addr_d = entries_q[head_q].addr;
            ram_wr_data_d = entries_q[head_q].data;
        end

        if (coalesce) begin
            entries_d[youngest].data = byte_merge(entries_q[youngest].data, sd.enq_data, sd.enq_be);
            entries_d[youngest].be   = entries_q[youngest].be | sd.enq_be;
        end else if (accept) begin
            entries_d[tail_q].valid = 1'b1;
            entries_d[tail_q].addr  = sd.enq_addr;
            entries_d[tail_q].data  = sd.enq_data;
            entries_d[tail_q].be    = sd.enq_be;
            tail_d = tail_q + PW'(1);
        end

        count_d = count_q + CW'(accept && !coalesce) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            ram_wr_en_q   <= '0;
            ram_wr_addr_q <= '0;
            ram_wr_data_q <= '0;
        end else begin
            entries_q     <= entries_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            ram_wr_en_q   <= ram_wr_en_d;
            ram_wr_addr_q <= ram_wr_addr_d;
            ram_wr_data_q <= ram_wr_data_d;
        end
    end

    assign sd.enq_ready   = enq_ready;
    assign sd.ram_wr_en   = ram_wr_en_q;
    assign sd.ram_wr_addr = ram_wr_addr_q;
    assign sd.ram_wr_data = ram_wr_data_q;
    assign sd.sb_empty    = (count_q == '0) && (ram_wr_en_q == '0);

    sd_hazard_cam #(
        .DEPTH (DEPTH)
    ) u_hazard_cam (
        .entries     (entries_q),
        .out_en      (ram_wr_en_q),
        .out_addr    (ram_wr_addr_q),
        .ld_valid    (sd.ld_valid),
        .ld_addr     (sd.ld_addr),
`ifdef STORE_DRAIN_FWD_EN
        .head        (head_q),
        .out_data    (ram_wr_data_q),
        .ld_fwd_data (sd.ld_fwd_data),
        .ld_fwd_be   (sd.ld_fwd_be),
`endif
        .ld_hit      (sd.ld_hit)
    );

endmodule

// File: tb/tb_dbram_store_drain.sv
// Self-checking bench for dbram_store_drain: directed scenarios plus randomized traffic
// against a queue-based store-buffer model. Forwarding checks under STORE_DRAIN_FWD_EN.
module tb_dbram_store_drain;

    localparam int DEPTH = 8;

    typedef struct {
        logic [9:0]  addr;
        logic [63:0] data;
        logic [7:0]  be;
    } mentry_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    dbram_store_drain_if #(.AW(10), .DW(64)) sd_if ();

    dbram_store_drain #(
        .DEPTH (DEPTH),
        .AW    (10),
        .DW    (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sd  (sd_if)
    );

    int total = 0;
    int bad   = 0;

    mentry_t     mq[$];
    logic [7:0]  m_out_en;
    logic [9:0]  m_out_addr;
    logic [63:0] m_out_data;

    logic        last_hit;
    logic        last_ready;
    logic [63:0] last_fwd_data;
    logic [7:0]  last_fwd_be;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic model_hit(input logic [9:0] a);
        logic h;
        h = 1'b0;
        foreach (mq[i]) begin
            if (mq[i].addr == a && mq[i].be != 8'h00) h = 1'b1;
        end
        if (m_out_en != 8'h00 && m_out_addr == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [63:0] merge_bytes(input logic [63:0] old_d, input logic [63:0] new_d, input logic [7:0] be);
        logic [63:0] r;
        r = old_d;
        for (int b = 0; b < 8; b++) begin
            if (be[b]) r[b*8 +: 8] = new_d[b*8 +: 8];
        end
        return r;
    endfunction

    function automatic void model_reset();
        mq.delete();
        m_out_en   = 8'h00;
        m_out_addr = 10'h000;
        m_out_data = 64'h0;
    endfunction

    // One clock: drive inputs, check combinational outputs against the model,
    // advance the model by one edge, then check the registered write port.
    task automatic applyStimulus(input logic ev, input logic [9:0] ea, input logic [63:0] ed,
                                 input logic [7:0] eb, input logic st, input logic lv,
                                 input logic [9:0] la, input logic r);
        logic    acc, pp, coal;
        mentry_t e;
        sd_if.enq_valid   = ev;
        sd_if.enq_addr    = ea;
        sd_if.enq_data    = ed;
        sd_if.enq_be      = eb;
        sd_if.drain_stall = st;
        sd_if.ld_valid    = lv;
        sd_if.ld_addr     = la;
        rst               = r;
        #1;
        last_ready = sd_if.enq_ready;
        last_hit   = sd_if.ld_hit;
        checkOutput("enq_ready", {63'b0, sd_if.enq_ready}, {63'b0, mq.size() != DEPTH});
        checkOutput("ld_hit", {63'b0, sd_if.ld_hit}, {63'b0, lv && model_hit(la)});
        checkOutput("sb_empty", {63'b0, sd_if.sb_empty}, {63'b0, mq.size() == 0 && m_out_en == 8'h00});
`ifdef STORE_DRAIN_FWD_EN
        begin
            logic [63:0] fd;
            logic [7:0]  fb;
            fd = 64'h0;
            fb = 8'h00;
            if (lv) begin
                if (m_out_en != 8'h00 && m_out_addr == la) begin
                    fd = merge_bytes(fd, m_out_data, m_out_en);
                    fb = fb | m_out_en;
                end
                foreach (mq[i]) begin
                    if (mq[i].addr == la) begin
                        fd = merge_bytes(fd, mq[i].data, mq[i].be);
                        fb = fb | mq[i].be;
                    end
                end
            end
            last_fwd_data = sd_if.ld_fwd_data;
            last_fwd_be   = sd_if.ld_fwd_be;
            checkOutput("ld_fwd_be", {56'b0, sd_if.ld_fwd_be}, {56'b0, fb});
            checkOutput("ld_fwd_data", sd_if.ld_fwd_data, fd);
        end
`endif
        if (r) begin
            model_reset();
        end else begin
            acc  = ev && (mq.size() != DEPTH);
            pp   = (mq.size() != 0) && !st;
            coal = acc && (mq.size() != 0) && (mq[$].addr == ea) && !(pp && mq.size() == 1);
            if (pp) begin
                e          = mq.pop_front();
                m_out_en   = e.be;
                m_out_addr = e.addr;
                m_out_data = e.data;
            end else begin
                m_out_en = 8'h00;
            end
            if (coal) begin
                e       = mq[$];
                e.data  = merge_bytes(e.data, ed, eb);
                e.be    = e.be | eb;
                mq[$]   = e;
            end else if (acc) begin
                e.addr = ea;
                e.data = ed;
                e.be   = eb;
                mq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        checkOutput("ram_wr_en", {56'b0, sd_if.ram_wr_en}, {56'b0, m_out_en});
        checkOutput("ram_wr_addr", {54'b0, sd_if.ram_wr_addr}, {54'b0, m_out_addr});
        checkOutput("ram_wr_data", sd_if.ram_wr_data, m_out_data);
        @(negedge clk);
    endtask

    task automatic idle(input logic st);
        applyStimulus(1'b0, 10'h000, 64'h0, 8'h00, st, 1'b0, 10'h000, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [0:3] hit_seq;
        sd_if.enq_valid   = 1'b0;
        sd_if.enq_addr    = '0;
        sd_if.enq_data    = '0;
        sd_if.enq_be      = '0;
        sd_if.drain_stall = 1'b0;
        sd_if.ld_valid    = 1'b0;
        sd_if.ld_addr     = '0;
        rst               = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();

        // Reset values, with a probe at the reset write address.
        sd_if.ld_valid = 1'b1;
        #1;
        checkOutput("rst_wr_en", {56'b0, sd_if.ram_wr_en}, 64'h0);
        checkOutput("rst_wr_addr", {54'b0, sd_if.ram_wr_addr}, 64'h0);
        checkOutput("rst_wr_data", sd_if.ram_wr_data, 64'h0);
        checkOutput("rst_enq_ready", {63'b0, sd_if.enq_ready}, 64'h1);
        checkOutput("rst_sb_empty", {63'b0, sd_if.sb_empty}, 64'h1);
        checkOutput("rst_ld_hit", {63'b0, sd_if.ld_hit}, 64'h0);
        @(negedge clk);

        $display("[TB] scenario: single store latency");
        applyStimulus(1'b1, 10'h005, 64'h1122334455667788, 8'hFF, 1'b0, 1'b0, 10'h000, 1'b0);
        checkOutput("t1_early_en", {56'b0, sd_if.ram_wr_en}, 64'h0);
        idle(1'b0);
        checkOutput("t1_en", {56'b0, sd_if.ram_wr_en}, 64'hFF);
        checkOutput("t1_addr", {54'b0, sd_if.ram_wr_addr}, 64'h005);
        checkOutput("t1_data", sd_if.ram_wr_data, 64'h1122334455667788);
        idle(1'b0);
        checkOutput("t1_sb_empty", {63'b0, sd_if.sb_empty}, 64'h1);

        $display("[TB] scenario: coalescing under stall");
        applyStimulus(1'b1, 10'h010, 64'hDEADBEEF_A1A2A3A4, 8'h0F, 1'b1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1'b1, 10'h010, 64'hB1B2B3B4_CAFEF00D, 8'hF0, 1'b1, 1'b0, 10'h000, 1'b0);
        idle(1'b0);
        checkOutput("t2_en", {56'b0, sd_if.ram_wr_en}, 64'hFF);
        checkOutput("t2_addr", {54'b0, sd_if.ram_wr_addr}, 64'h010);
        checkOutput("t2_data", sd_if.ram_wr_data, 64'hB1B2B3B4_A1A2A3A4);
        idle(1'b0);
        checkOutput("t2_single_write", {56'b0, sd_if.ram_wr_en}, 64'h0);

        $display("[TB] scenario: fill to full and drain in order");
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b1, 10'(32'h40 + i), {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 10'h000, 1'b0);
        end
        applyStimulus(1'b1, 10'h0FF, 64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b0, 10'h000, 1'b0);
        checkOutput("t3_full_ready", {63'b0, last_ready}, 64'h0);
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b0);
            checkOutput("t3_order_addr", {54'b0, sd_if.ram_wr_addr}, 64'(32'h40 + i));
            checkOutput("t3_order_en", {56'b0, sd_if.ram_wr_en}, 64'hFF);
        end
        idle(1'b0);
        checkOutput("t3_dropped", {56'b0, sd_if.ram_wr_en}, 64'h0);

        $display("[TB] scenario: load hazard window");
        hit_seq[0] = 1'b0;
        applyStimulus(1'b1, 10'h020, 64'h5555AAAA5555AAAA, 8'hFF, 1'b0, 1'b1, 10'h020, 1'b0);
        hit_seq[0] = last_hit;
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b0, 10'h000, 64'h0, 8'h00, 1'b0, 1'b1, 10'h020, 1'b0);
            hit_seq[k] = last_hit;
        end
        checkOutput("t4_hit_seq", {60'b0, hit_seq}, 64'b0110);
        applyStimulus(1'b1, 10'h020, 64'h5555AAAA5555AAAA, 8'hFF, 1'b0, 1'b1, 10'h021, 1'b0);
        hit_seq[0] = last_hit;
        for (int k = 1; k < 4; k++) begin
            applyStimulus(1'b0, 10'h000, 64'h0, 8'h00, 1'b0, 1'b1, 10'h021, 1'b0);
            hit_seq[k] = last_hit;
        end
        checkOutput("t4_miss_seq", {60'b0, hit_seq}, 64'b0000);

        $display("[TB] scenario: reset with pending stores");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 10'(32'h60 + i), {$urandom, $urandom}, 8'hFF, 1'b1, 1'b0, 10'h000, 1'b0);
        end
        applyStimulus(1'b0, 10'h000, 64'h0, 8'h00, 1'b0, 1'b0, 10'h000, 1'b1);
        checkOutput("t5_en_after_rst", {56'b0, sd_if.ram_wr_en}, 64'h0);
        checkOutput("t5_sb_empty", {63'b0, sd_if.sb_empty}, 64'h1);
        checkOutput("t5_enq_ready", {63'b0, sd_if.enq_ready}, 64'h1);
        for (int i = 0; i < 3; i++) begin
            idle(1'b0);
            checkOutput("t5_no_write", {56'b0, sd_if.ram_wr_en}, 64'h0);
        end

`ifdef STORE_DRAIN_FWD_EN
        $display("[TB] scenario: youngest-first forwarding");
        applyStimulus(1'b1, 10'h030, 64'h11, 8'h01, 1'b1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1'b1, 10'h031, 64'h22, 8'h01, 1'b1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1'b1, 10'h030, 64'h3344, 8'h03, 1'b1, 1'b0, 10'h000, 1'b0);
        applyStimulus(1'b0, 10'h000, 64'h0, 8'h00, 1'b1, 1'b1, 10'h030, 1'b0);
        checkOutput("t6_fwd_be", {56'b0, last_fwd_be}, 64'h03);
        checkOutput("t6_fwd_bytes", {48'b0, last_fwd_data[15:0]}, 64'h3344);
        repeat (5) idle(1'b0);
`endif

        $display("[TB] scenario: randomized traffic");
        for (int c = 0; c < 3000; c++) begin
            logic heavy;
            heavy = ((c / 100) % 2) == 1;
            applyStimulus(($urandom % 10) < 7,
                          10'($urandom_range(0, 5)),
                          {$urandom, $urandom},
                          (($urandom % 8) == 0) ? 8'h00 : 8'($urandom),
                          heavy ? (($urandom % 10) < 8) : (($urandom % 10) < 3),
                          ($urandom % 4) != 0,
                          10'($urandom_range(0, 5)),
                          ($urandom % 250) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
